// File: rtl/mult_sched_pkg.sv
// Shared constants, tag-pipeline entry type and one-hot helper for the multiplier scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mult_sched_pkg;

    localparam int MS_N        = 16;
    localparam int MS_NUM_REQ  = 4;
    localparam int MS_MULT_LAT = 0;
    localparam int MS_ID_W     = 2;

    // Widest tag ever needed (NUM_REQ up to 16); narrower configs zero-extend.
    localparam int ID_MAX_W    = 4;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_ent_t;

    function automatic logic [15:0] onehot_from_id(input logic [ID_MAX_W-1:0] id);
        onehot_from_id = 16'd1 << id;
    endfunction

endpackage

// File: rtl/mult_sched_arb_if.sv
// Requester-side bundle: operand valid/ready and the one-hot response strobe.
// Latency: n/a (wires only).
// Backpressure: ready is a grant; responses carry no backpressure.
interface mult_sched_arb_if #(
    parameter int N       = 16,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*N-1:0] req_a;
    logic [NUM_REQ*N-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [N-1:0]         resp_y;

    // Lane side drives operands and consumes grants/results.
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_y
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_y
    );
endinterface

// File: rtl/mult_sched_arb_rr_arbiter.sv
// Round-robin grant generator; pointer moves past the winner on every accepted transfer.
// Latency: grant is combinational from req/enable and the registered pointer.
// Backpressure: no grant while enable is low or reset is asserted; pointer holds.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic               accept,
    output logic [NUM_REQ-1:0] gnt
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               gnt_idx;
    int               scan_idx;

    // Scan upward from the pointer with wrap; first requester found wins.
    always_comb begin
        gnt      = '0;
        found    = 1'b0;
        gnt_idx  = 0;
        scan_idx = 0;
        if (enable && rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = int'(ptr_q) + k;
                if (scan_idx >= NUM_REQ) begin
                    scan_idx = scan_idx - NUM_REQ;
                end
                if (!found && req[scan_idx]) begin
                    found        = 1'b1;
                    gnt_idx      = scan_idx;
                    gnt[scan_idx] = 1'b1;
                end
            end
        end
    end

    // Advance the pointer to one past the winner only when a transfer happened.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx == NUM_REQ - 1) ? '0 : PTR_W'(gnt_idx + 1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/mult_sched_arb.sv
// Shares one external multiplier among NUM_REQ lanes: RR grant, operand regs, tag pipe, result reg.
// Latency: accept in cycle t -> resp_valid in cycle t+2+MULT_LAT; one accept per cycle, never stalls.
// Backpressure: only via grant (req_ready); responses have none. MULT_SCHED_STATS_EN adds grant counters.
module mult_sched_arb
    import mult_sched_pkg::*;
#(
    parameter int N        = MS_N,
    parameter int NUM_REQ  = MS_NUM_REQ,
    parameter int MULT_LAT = MS_MULT_LAT,
    parameter int ID_W     = MS_ID_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    mult_sched_arb_if.slave  rq,
    output logic [N-1:0]     mult_a,
    output logic [N-1:0]     mult_b,
    input  logic [N-1:0]     mult_y,
    output logic             busy
`ifdef MULT_SCHED_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);
    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    logic [N-1:0]       sel_a, sel_b;
    logic [ID_W-1:0]    sel_id;

    logic [N-1:0]       mult_a_q, mult_a_d;
    logic [N-1:0]       mult_b_q, mult_b_d;
    logic [N-1:0]       resp_y_q, resp_y_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    tag_ent_t           pipe_q [MULT_LAT+1];
    tag_ent_t           pipe_d [MULT_LAT+1];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (rq.req_valid),
        .enable (enable),
        .accept (accept),
        .gnt    (gnt)
    );

    assign accept        = |(gnt & rq.req_valid);
    assign rq.req_ready  = gnt;
    assign rq.resp_valid = resp_valid_q;
    assign rq.resp_y     = resp_y_q;
    assign mult_a        = mult_a_q;
    assign mult_b        = mult_b_q;

    // One-hot grant steers the winning lane's operands and id.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a  = rq.req_a[i*N +: N];
                sel_b  = rq.req_b[i*N +: N];
                sel_id = ID_W'(i);
            end
        end
    end

    // Operand capture, tag shift and result capture; idle cycles hold data to avoid toggling.
    always_comb begin
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        pipe_d[0]    = '0;
        resp_valid_d = '0;
        resp_y_d     = resp_y_q;
        if (accept) begin
            mult_a_d        = sel_a;
            mult_b_d        = sel_b;
            pipe_d[0].valid = 1'b1;
            pipe_d[0].id    = ID_MAX_W'(sel_id);
        end
        for (int s = 1; s <= MULT_LAT; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
        if (pipe_q[MULT_LAT].valid) begin
            resp_valid_d = NUM_REQ'(onehot_from_id(pipe_q[MULT_LAT].id));
            resp_y_d     = mult_y;
        end
    end

    // Datapath and tag registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            resp_y_q     <= '0;
            resp_valid_q <= '0;
            for (int s = 0; s <= MULT_LAT; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            resp_y_q     <= resp_y_d;
            resp_valid_q <= resp_valid_d;
            pipe_q       <= pipe_d;
        end
    end

    // Busy while any stage holds an op or a strobe is on the output.
    always_comb begin
        busy = |resp_valid_q;
        for (int s = 0; s <= MULT_LAT; s++) begin
            busy = busy | pipe_q[s].valid;
        end
    end

`ifdef MULT_SCHED_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];

    // Saturating per-lane grant counters; clear wins over increment.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stats_clr) begin
                cnt_d[i] = '0;
            end else if (accept && gnt[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Pack counters lane-major like the operand buses.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_mult_sched_arb.sv
// Bench for mult_sched_arb: two instances (MULT_LAT=0 and MULT_LAT=2) share stimulus.
// Expected values come from a queue-based model of grants and pending responses.
// Optional grant-counter checks compile only with MULT_SCHED_STATS_EN.
module tb_mult_sched_arb;
    localparam int N  = 16;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    mult_sched_arb_if #(.N(N), .NUM_REQ(NR)) rq0 ();
    mult_sched_arb_if #(.N(N), .NUM_REQ(NR)) rq2 ();

    logic [NR-1:0]   vld = '0;
    logic [NR*N-1:0] va = '0;
    logic [NR*N-1:0] vb = '0;

    assign rq0.req_valid = vld;
    assign rq0.req_a     = va;
    assign rq0.req_b     = vb;
    assign rq2.req_valid = vld;
    assign rq2.req_a     = va;
    assign rq2.req_b     = vb;

    logic [N-1:0] ma0, mb0, my0, ma2, mb2, my2;
    logic         busy0, busy2;

    // Combinational multiplier for the MULT_LAT=0 instance.
    wire [2*N-1:0] p0 = ma0 * mb0;
    assign my0 = p0[N-1:0];

    // Two-register multiplier for the MULT_LAT=2 instance.
    wire [2*N-1:0] p2 = ma2 * mb2;
    logic [N-1:0] r1 = '0, r2 = '0;
    always @(posedge clk) begin
        r1 <= p2[N-1:0];
        r2 <= r1;
    end
    assign my2 = r2;

`ifdef MULT_SCHED_STATS_EN
    logic stats_clr = 1'b0;
    logic [NR*16-1:0] gc0, gc2;
`endif

    mult_sched_arb #(.N(N), .NUM_REQ(NR), .MULT_LAT(0), .ID_W(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rq(rq0),
        .mult_a(ma0), .mult_b(mb0), .mult_y(my0), .busy(busy0)
`ifdef MULT_SCHED_STATS_EN
        , .stats_clr(stats_clr), .grant_cnt(gc0)
`endif
    );

    mult_sched_arb #(.N(N), .NUM_REQ(NR), .MULT_LAT(2), .ID_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rq(rq2),
        .mult_a(ma2), .mult_b(mb2), .mult_y(my2), .busy(busy2)
`ifdef MULT_SCHED_STATS_EN
        , .stats_clr(stats_clr), .grant_cnt(gc2)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        int           acc;
        int           id;
        logic [N-1:0] y;
    } pend_t;

    pend_t        pq[$];
    int           ptr;
    int           cyc;
    logic [N-1:0] last_a, last_b;
    logic [N-1:0] last_y [2];
    int           gcount [NR];
    int           errs = 0;
    int           checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] model_gnt();
        logic [NR-1:0] g = '0;
        if (enable && rst_n) begin
            for (int k = 0; k < NR; k++) begin
                if (g == '0 && vld[(ptr + k) % NR]) g[(ptr + k) % NR] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        pq.delete();
        ptr = 0;
        last_a = '0;
        last_b = '0;
        last_y[0] = '0;
        last_y[1] = '0;
        for (int i = 0; i < NR; i++) gcount[i] = 0;
    endtask

    // Response/busy expectations for the instance with latency 2*L.
    task automatic chk_dut(input int L, input logic [NR-1:0] rv, input logic [N-1:0] y, input logic b);
        int            lat = 2 * L;
        logic [NR-1:0] erv = '0;
        logic          eb = 1'b0;
        foreach (pq[j]) begin
            if (pq[j].acc + 2 + lat == cyc) begin
                erv = NR'(1) << pq[j].id;
                last_y[L] = pq[j].y;
            end
            if (pq[j].acc < cyc && cyc <= pq[j].acc + 2 + lat) eb = 1'b1;
        end
        chk($sformatf("resp_valid_lat%0d", lat), 64'(rv), 64'(erv));
        chk($sformatf("resp_y_lat%0d", lat), 64'(y), 64'(last_y[L]));
        chk($sformatf("busy_lat%0d", lat), 64'(b), 64'(eb));
    endtask

    task automatic check_outputs();
        chk_dut(0, rq0.resp_valid, rq0.resp_y, busy0);
        chk_dut(1, rq2.resp_valid, rq2.resp_y, busy2);
        chk("mult_a", 64'(ma0), 64'(last_a));
        chk("mult_b", 64'(mb0), 64'(last_b));
        chk("mult_a_lat2", 64'(ma2), 64'(last_a));
        while (pq.size() > 0 && pq[0].acc + 4 <= cyc) void'(pq.pop_front());
    endtask

    // One clock: apply inputs, check grant, clock, update model, check registered outputs.
    task automatic step(input logic [NR-1:0] v, input logic en, output logic [NR-1:0] g_seen);
        logic [NR-1:0]  eg;
        logic [2*N-1:0] pp;
        int             id;
        vld = v;
        enable = en;
        #1;
        eg = model_gnt();
        g_seen = rq0.req_ready;
        chk("req_ready", 64'(rq0.req_ready), 64'(eg));
        chk("req_ready_lat2", 64'(rq2.req_ready), 64'(eg));
        @(posedge clk);
        if (eg != '0) begin
            id = 0;
            for (int i = 0; i < NR; i++) if (eg[i]) id = i;
            last_a = va[id*N +: N];
            last_b = vb[id*N +: N];
            pp = last_a * last_b;
            pq.push_back('{acc: cyc, id: id, y: pp[N-1:0]});
            ptr = (id + 1) % NR;
            gcount[id]++;
        end
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int hold);
        vld = '1;
        enable = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_req_ready", 64'(rq0.req_ready), 64'(0));
        chk("rst_resp_valid", 64'(rq0.resp_valid | rq2.resp_valid), 64'(0));
        chk("rst_busy", 64'({busy0, busy2}), 64'(0));
        chk("rst_mult_a", 64'(ma0), 64'(0));
        chk("rst_resp_y", 64'(rq0.resp_y), 64'(0));
        repeat (hold) @(posedge clk);
        cyc += hold;
        #1;
        vld = '0;
        rst_n = 1'b1;
    endtask

    task automatic set_ops(input int base, input int bmul);
        for (int i = 0; i < NR; i++) begin
            va[i*N +: N] = N'(base + i);
            vb[i*N +: N] = N'(bmul);
        end
    endtask

    typedef struct {
        logic [NR-1:0] v;
        logic          en;
        logic [NR-1:0] g;
    } vec_t;

    vec_t          tab [10];
    logic [NR-1:0] g;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        model_reset();
        #2;
        do_reset(3);

        // Idle after reset: nothing moves.
        repeat (3) step('0, 1'b1, g);

        // Grant table from pointer 0; includes wrap, sparse and enable-low rows.
        tab[0] = '{4'b0000, 1'b1, 4'b0000};
        tab[1] = '{4'b0001, 1'b1, 4'b0001};
        tab[2] = '{4'b0001, 1'b1, 4'b0001};
        tab[3] = '{4'b1111, 1'b1, 4'b0010};
        tab[4] = '{4'b1001, 1'b1, 4'b1000};
        tab[5] = '{4'b1001, 1'b1, 4'b0001};
        tab[6] = '{4'b1111, 1'b0, 4'b0000};
        tab[7] = '{4'b0100, 1'b1, 4'b0100};
        tab[8] = '{4'b1111, 1'b1, 4'b1000};
        tab[9] = '{4'b0110, 1'b1, 4'b0010};
        for (int k = 0; k < 10; k++) begin
            set_ops(k * 8 + 1, k + 2);
            step(tab[k].v, tab[k].en, g);
            chk($sformatf("tab_gnt[%0d]", k), 64'(g), 64'(tab[k].g));
        end
        repeat (5) step('0, 1'b1, g);

        // Single op: 3*5 returns two cycles later on lane 0.
        do_reset(2);
        set_ops(3, 5);
        step(4'b0001, 1'b1, g);
        chk("single_busy", 64'(busy0), 64'(1));
        step('0, 1'b1, g);
        chk("single_rv", 64'(rq0.resp_valid), 64'(4'b0001));
        chk("single_y", 64'(rq0.resp_y), 64'(15));
        repeat (4) step('0, 1'b1, g);

        // Full contention: strict rotation, products 2,4,6,8.
        do_reset(2);
        set_ops(1, 2);
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b1, g);
            chk("rotation", 64'(g), 64'(NR'(1) << (k % NR)));
        end
        repeat (5) step('0, 1'b1, g);

        // Sparse: move pointer to 2, then lanes 0 and 3 -> 3 first, then 0.
        step(4'b0010, 1'b1, g);
        step(4'b1001, 1'b1, g);
        chk("sparse_first", 64'(g), 64'(4'b1000));
        step(4'b1001, 1'b1, g);
        chk("sparse_second", 64'(g), 64'(4'b0001));
        repeat (5) step('0, 1'b1, g);

        // Enable drop with two in flight.
        set_ops(7, 9);
        step(4'b1111, 1'b1, g);
        step(4'b1111, 1'b1, g);
        step(4'b1111, 1'b0, g);
        chk("en_drop_gnt", 64'(g), 64'(0));
        repeat (4) step(4'b1111, 1'b0, g);
        chk("en_drop_idle", 64'({busy0, busy2}), 64'(0));

        // Reset the cycle after an accept: result is lost.
        set_ops(11, 13);
        step(4'b0100, 1'b1, g);
        do_reset(2);
        for (int k = 0; k < 6; k++) begin
            step('0, 1'b1, g);
            chk("post_rst_rv", 64'(rq0.resp_valid | rq2.resp_valid), 64'(0));
        end

        // Randomized traffic.
        do_reset(2);
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NR; i++) begin
                va[i*N +: N] = N'($urandom);
                vb[i*N +: N] = N'($urandom);
            end
            step(NR'($urandom), ($urandom_range(0, 9) != 0), g);
        end
        repeat (6) step('0, 1'b1, g);

`ifdef MULT_SCHED_STATS_EN
        for (int i = 0; i < NR; i++) begin
            chk("grant_cnt", 64'(gc0[i*16 +: 16]), 64'(gcount[i]));
            chk("grant_cnt_lat2", 64'(gc2[i*16 +: 16]), 64'(gcount[i]));
        end
        do_reset(2);
        set_ops(5, 6);
        repeat (10) step(4'b0010, 1'b1, g);
        repeat (6) step('0, 1'b1, g);
        chk("grant_cnt_req1", 64'(gc2[16 +: 16]), 64'(10));
        stats_clr = 1'b1;
        step(4'b0010, 1'b1, g);
        stats_clr = 1'b0;
        chk("grant_cnt_clr", 64'(gc2[16 +: 16]), 64'(0));
        repeat (6) step('0, 1'b1, g);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mult_sched_arb.md
Name: mult_sched_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational m_mult instance between NUM_REQ requesters (e.g. neuron-lane partial-product units).
- Holds the operand pipeline registers that sit in front of the multiplier. Tracks requester tags alongside each operation. Returns each product to its requester with a one-hot response strobe.
- Sits between the lane datapaths and the shared multiplier in the DNN compute tile.

Parameters:
- N, 16, operand/result width (matches multiplier).
- NUM_REQ, 4, number of requesters (2..16).
- MULT_LAT, 0, extra register stages inside the external multiplier path (0 = combinational m_mult).
- ID_W, 2, tag width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  grant enable; when 0, no new grants are issued and in-flight operations still drain.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_a  in  NUM_REQ*N  packed operand A; requester i uses bits [i*N +: N].
- req_b  in  NUM_REQ*N  packed operand B, same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i] at the clock edge.
- mult_a  out  N  registered operand A to the multiplier.
- mult_b  out  N  registered operand B to the multiplier.
- mult_y  in  N  multiplier result, valid MULT_LAT cycles after mult_a/mult_b.
- resp_valid  out  NUM_REQ  one-hot result strobe, one cycle wide.
- resp_y  out  N  registered product (low N bits, as produced by the multiplier).
- busy  out  1  any operation in flight or a response pending.

Behaviour:
- Reset (rst_n=0, async):
  - mult_a, mult_b, resp_y = 0.
  - resp_valid = 0; busy = 0.
  - Round-robin pointer = 0.
  - All in-flight tags and valids cleared; any pending results are discarded.
- Grant (combinational):
  - req_ready = 0 when enable=0 or rst_n=0.
  - Otherwise, assert req_ready for the first i with req_valid[i]=1, scanning from pointer upward with wrap modulo NUM_REQ.
  - At most one bit set. Never assert req_ready for a requester whose req_valid=0.
- Pointer update:
  - On an accepted transfer by requester i, pointer <= (i+1) mod NUM_REQ.
  - With no transfer, the pointer holds.
- Throughput: one accepted operation per cycle; the block never stalls.
- Pipeline:
  - Stage S0 (accept edge): mult_a/mult_b <= selected operands; tag0 <= i; v0 <= 1.
  - With no accept, v0 <= 0 and mult_a/mult_b hold their last value (no toggling).
  - Stages S1..S_MULT_LAT: tag/valid shift register, advancing one stage per cycle.
  - Result edge: resp_y <= mult_y and resp_valid <= onehot(tag) when the final stage is valid; otherwise resp_valid <= 0 and resp_y holds.
- Latency: accept in cycle t, then resp_valid is high in cycle t+2+MULT_LAT (2 cycles at default).
- Responses:
  - Returned in acceptance order.
  - No output backpressure; requesters must sample resp_valid/resp_y in the strobe cycle.
- busy = OR of all stage valids and resp_valid.
- Boundary conditions:
  - All requesters valid: strict rotation 0,1,2,3,0,… with one grant per cycle.
  - Single requester continuously valid: granted every cycle.
  - enable falling mid-stream: grants stop the same cycle; queued results still emerge; busy falls after the last resp_valid.
  - Reset mid-operation: in-flight results are lost and no resp_valid is produced afterward.
  - Pointer wraps from NUM_REQ-1 to 0.

Optional Feature:
- MULT_SCHED_STATS_EN defined:
  - Adds per-requester 16-bit grant counters, exposed as output grant_cnt (NUM_REQ*16, packed like req_a).
  - Counters reset to 0 on rst_n and saturate at 0xFFFF.
  - Adds input stats_clr (1), a synchronous clear that takes priority over increment in the same cycle.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mult_sched_pkg:
  - Default N/NUM_REQ/MULT_LAT constants.
  - Function onehot_from_id.
  - Typedef for the tag/valid pipeline entry {valid, id}.
- One sub-module: rr_arbiter (parameter NUM_REQ), holding the round-robin pointer.
  - Inputs: req, enable, accept.
  - Output: one-hot gnt.
- mult_sched_arb instantiates rr_arbiter, the operand registers, the tag pipeline and the result register. m_mult stays external.

Test Plan:
- Reset/idle: hold rst_n=0, then release with no req_valid → all outputs 0, busy=0, mult_a/b stay 0.
- Single op: req0 with a=3, b=5 accepted in cycle 10 → resp_valid=4'b0001 and resp_y=15 in cycle 12; busy high in cycles 11–12.
- Full contention: all 4 valid for 8 cycles, operands a=i+1, b=2 → grants in order 0,1,2,3,0,1,2,3; products 2,4,6,8 repeating, arriving 2 cycles after each accept.
- Sparse round-robin: pointer at 2, only req0 and req3 valid → grant 3 first, then 0.
- enable drop and reset mid-flight:
  - Deassert enable with 2 ops in flight → req_ready=0 immediately; both responses delivered; busy=0 after.
  - Repeat, but pulse rst_n low the cycle after the accept → no resp_valid produced.
- MULT_LAT=2 build with a 2-register multiplier model and MULT_SCHED_STATS_EN: 10 grants to req1 → response latency 4 cycles; grant_cnt for req1 = 10; stats_clr clears it to 0.
